// File: rtl/instr_pointer_stack_pkg.sv
// Shared encodings and defaults for the instruction pointer with return stack.
package instr_pointer_stack_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE = 16;

    localparam logic [1:0] MODE_REL  = 2'b00;
    localparam logic [1:0] MODE_ABS  = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;
    localparam logic [1:0] MODE_RET  = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } ips_state_e;

endpackage

// File: rtl/ip_return_stack.sv
// Bounded LIFO of return addresses; reset clears only the pointer, not the array.
module ip_return_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_ptr;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_ptr == DW'(DEPTH));
    assign empty     = (r_ptr == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_wr_idx  = AW'(r_ptr);
    assign w_rd_idx  = AW'(r_ptr - DW'(1));
    assign rdata     = empty ? '0 : r_mem[w_rd_idx];
    assign depth     = r_ptr;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + DW'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - DW'(1);
        end
    end

endmodule

// File: rtl/instr_pointer_stack.sv
// Instruction pointer with REL/ABS/CALL/RET update and a fault FSM that freezes on stack misuse.
module instr_pointer_stack
    import instr_pointer_stack_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RESET_ADDR  = 0,
    parameter int unsigned RET_INC     = 1,
    localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WORD_SIZE-1:0] adj,
    input  logic [WORD_SIZE-1:0] target,
    output logic [WORD_SIZE-1:0] out,
    output logic [DW-1:0]        depth,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 fault
);
    ips_state_e           r_state, w_state_nxt;
    logic [WORD_SIZE-1:0] r_out, w_out_nxt;
    logic                 r_ovf, w_ovf_nxt;
    logic                 r_unf, w_unf_nxt;

    logic                 w_push, w_pop;
    logic [WORD_SIZE-1:0] w_ret_addr;
    logic [WORD_SIZE-1:0] w_top;
    logic                 w_full, w_empty;

    assign w_ret_addr = r_out + WORD_SIZE'(RET_INC);

    ip_return_stack #(
        .WIDTH (WORD_SIZE),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_ret_addr),
        .rdata (w_top),
        .depth (depth),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (r_state == ST_RUN && en) begin
            unique case (mode)
                MODE_REL: w_out_nxt = r_out + adj;
                MODE_ABS: w_out_nxt = target;
                MODE_CALL: begin
                    if (!w_full) begin
                        w_push    = 1'b1;
                        w_out_nxt = target;
                    end else begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end
                end
                MODE_RET: begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_out_nxt = w_top;
                    end else begin
                        w_unf_nxt   = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_out   <= WORD_SIZE'(RESET_ADDR);
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    assign out       = r_out;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_instr_pointer_stack.sv
// Directed and random checks of instr_pointer_stack against a queue-based reference model.
module tb_instr_pointer_stack;
    import instr_pointer_stack_pkg::*;

    localparam int unsigned W     = 16;
    localparam int unsigned SD    = 4;
    localparam int unsigned DW    = $clog2(SD + 1);
    localparam int unsigned RADDR = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = MODE_REL;
    logic [W-1:0]  adj = '0;
    logic [W-1:0]  target = '0;
    logic [W-1:0]  out;
    logic [DW-1:0] depth;
    logic          overflow, underflow, fault;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] m_out = '0;
    logic [W-1:0] m_stack[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    instr_pointer_stack #(
        .WORD_SIZE   (W),
        .STACK_DEPTH (SD),
        .RESET_ADDR  (RADDR),
        .RET_INC     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .adj       (adj),
        .target    (target),
        .out       (out),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_out = W'(RADDR);
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (en && !(m_ovf || m_unf)) begin
            case (mode)
                MODE_REL: m_out = m_out + adj;
                MODE_ABS: m_out = target;
                MODE_CALL: begin
                    if (m_stack.size() < SD) begin
                        m_stack.push_back(m_out + W'(1));
                        m_out = target;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                default: begin
                    if (m_stack.size() > 0) m_out = m_stack.pop_back();
                    else m_unf = 1'b1;
                end
            endcase
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic [1:0] md,
                        input logic [W-1:0] a, input logic [W-1:0] t);
        reset  = r;
        en     = e;
        mode   = md;
        adj    = a;
        target = t;
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".out"}, 32'(out), 32'(m_out));
        check({tag, ".depth"}, 32'(depth), 32'(m_stack.size()));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        check({tag, ".fault"}, 32'(fault), 32'(m_ovf | m_unf));
    endtask

    initial begin
        // Reset and relative stepping
        step("reset", 1'b1, 1'b0, MODE_REL, '0, '0);
        check("reset_addr", 32'(out), 32'(RADDR));
        for (int i = 0; i < 3; i++) step("rel_p4", 1'b0, 1'b1, MODE_REL, 16'd4, '0);
        check("rel_12", 32'(out), 32'd12);
        step("rel_m2", 1'b0, 1'b1, MODE_REL, 16'hFFFE, '0);
        check("rel_10", 32'(out), 32'd10);

        // Wraparound both ways
        step("abs_fffe", 1'b0, 1'b1, MODE_ABS, '0, 16'hFFFE);
        step("wrap_up", 1'b0, 1'b1, MODE_REL, 16'd3, '0);
        check("wrap_0001", 32'(out), 32'h0001);
        step("wrap_dn", 1'b0, 1'b1, MODE_REL, 16'hFFFE, '0);
        check("wrap_ffff", 32'(out), 32'hFFFF);

        // Nested call/return, back-to-back with no gap
        step("abs_10", 1'b0, 1'b1, MODE_ABS, '0, 16'h0010);
        step("call1", 1'b0, 1'b1, MODE_CALL, '0, 16'h0100);
        step("call2", 1'b0, 1'b1, MODE_CALL, '0, 16'h0200);
        step("ret1", 1'b0, 1'b1, MODE_RET, '0, '0);
        check("ret_101", 32'(out), 32'h0101);
        step("ret2", 1'b0, 1'b1, MODE_RET, '0, '0);
        check("ret_11", 32'(out), 32'h0011);

        // Overflow and frozen fault state
        for (int i = 0; i < SD; i++) step("fill", 1'b0, 1'b1, MODE_CALL, '0, W'(16'h0300 + i));
        step("ovf", 1'b0, 1'b1, MODE_CALL, '0, 16'h0999);
        check("ovf_flag", 32'(overflow), 32'd1);
        step("frz_rel", 1'b0, 1'b1, MODE_REL, 16'd7, '0);
        step("frz_abs", 1'b0, 1'b1, MODE_ABS, '0, 16'h1234);
        step("frz_ret", 1'b0, 1'b1, MODE_RET, '0, '0);
        step("ovf_rst", 1'b1, 1'b1, MODE_ABS, '0, 16'h4321);

        // Underflow, then reset colliding with an enabled op
        step("abs_77", 1'b0, 1'b1, MODE_ABS, '0, 16'h0077);
        step("unf", 1'b0, 1'b1, MODE_RET, '0, '0);
        check("unf_out", 32'(out), 32'h0077);
        step("unf_rst", 1'b1, 1'b1, MODE_CALL, '0, 16'h0555);
        check("unf_clr", 32'(underflow), 32'd0);

        // Enable gating
        step("pre_call", 1'b0, 1'b1, MODE_CALL, '0, 16'h0040);
        for (int i = 0; i < 5; i++) step("en0", 1'b0, 1'b0, MODE_ABS, '0, 16'h0055);
        step("en1", 1'b0, 1'b1, MODE_ABS, '0, 16'h0055);
        check("en_55", 32'(out), 32'h0055);

        // Random traffic; reset more likely while faulted so the run keeps moving
        for (int i = 0; i < 600; i++) begin
            logic          r;
            logic          e;
            logic [1:0]    md;
            logic [W-1:0]  a;
            logic [W-1:0]  t;
            r  = (m_ovf || m_unf) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 3) != 0);
            md = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            t  = W'($urandom);
            step("rand", r, e, md, a, t);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
